// File: rtl/fp_pkg.sv
// Shared floating-point word definitions for the OFDM datapath.
// Default field widths, word type and the sign-flip helper.
package fp_pkg;

   localparam int I_EXP = 8;
   localparam int I_MNT = 23;
   localparam int FP_W  = 1 + I_EXP + I_MNT;

   typedef logic [FP_W-1:0] fp_t;

   localparam fp_t FP_ZERO = '0;

   function automatic fp_t fp_neg(input fp_t x);
      return {~x[FP_W-1], x[FP_W-2:0]};
   endfunction

endpackage

// File: rtl/fp_cmul_seq_tag_pipe.sv
// Latency-matched tag shift register tracking ops in flight in the FMA.
// A push in cycle k is presented on exit_valid/exit_id in cycle k+DEPTH.
module fp_tag_pipe #(
   parameter int DEPTH = 3,
   parameter int IDW   = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           push,
   input  logic [IDW-1:0] push_id,
   output logic           exit_valid,
   output logic [IDW-1:0] exit_id
);

   logic           v_q  [DEPTH];
   logic [IDW-1:0] id_q [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            v_q[i]  <= 1'b0;
            id_q[i] <= '0;
         end
      end else begin
         v_q[0]  <= push;
         id_q[0] <= push_id;
         for (int i = 1; i < DEPTH; i++) begin
            v_q[i]  <= v_q[i-1];
            id_q[i] <= id_q[i-1];
         end
      end
   end

   assign exit_valid = v_q[DEPTH-1];
   assign exit_id    = id_q[DEPTH-1];

endmodule

// File: rtl/fp_cmul_seq.sv
// Complex multiply sequencer: issues four FMA ops in two dependent passes
// and returns y = a*b over a valid/ready handshake.
module fp_cmul_seq
   import fp_pkg::*;
#(
   parameter int I_EXP      = fp_pkg::I_EXP,
   parameter int I_MNT      = fp_pkg::I_MNT,
   parameter int DATA_WIDTH = 1 + I_EXP + I_MNT,
   parameter int FMA_LAT    = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a_re,
   input  logic [DATA_WIDTH-1:0] in_a_im,
   input  logic [DATA_WIDTH-1:0] in_b_re,
   input  logic [DATA_WIDTH-1:0] in_b_im,
   output logic                  fma_enable,
   output logic [DATA_WIDTH-1:0] fma_a,
   output logic [DATA_WIDTH-1:0] fma_b,
   output logic [DATA_WIDTH-1:0] fma_c,
   input  logic [DATA_WIDTH-1:0] fma_result,
   input  logic                  fma_valid,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_re,
   output logic [DATA_WIDTH-1:0] out_im,
   output logic                  seq_err
);

   localparam int DW = DATA_WIDTH;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_P1_RE = 3'd1;
   localparam logic [2:0] S_P1_IM = 3'd2;
   localparam logic [2:0] S_W1    = 3'd3;
   localparam logic [2:0] S_P2_RE = 3'd4;
   localparam logic [2:0] S_P2_IM = 3'd5;
   localparam logic [2:0] S_W2    = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   typedef enum logic [1:0] {
      T_RE1 = 2'd0,
      T_IM1 = 2'd1,
      T_RE2 = 2'd2,
      T_IM2 = 2'd3
   } tag_id_t;

   logic [2:0]    state, state_nx;
   logic          en_q;
   logic          err_q;
   logic          have_re, have_im;
   logic [DW-1:0] ar, ai, br, bi;
   logic [DW-1:0] re_p, im_p;

   logic          push;
   tag_id_t       push_id;
   logic          exit_v;
   logic [1:0]    exit_id;

   logic          accept;
   logic          cap_re1, cap_im1, cap_im2;

   fp_tag_pipe #(
      .DEPTH (FMA_LAT),
      .IDW   (2)
   ) u_tags (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_id    (push_id),
      .exit_valid (exit_v),
      .exit_id    (exit_id)
   );

   assign fma_enable = en_q;
   assign in_ready   = en_q & (state == S_IDLE);
   assign out_valid  = (state == S_DONE);
   assign accept     = in_valid & in_ready;

   assign cap_re1 = exit_v & (exit_id == T_RE1);
   assign cap_im1 = exit_v & (exit_id == T_IM1);
   assign cap_im2 = exit_v & (exit_id == T_IM2);

   // Error visible in the very cycle the unmatched tag exits
   assign seq_err = err_q | (exit_v & ~fma_valid);

   always_comb begin
      fma_a   = '0;
      fma_b   = '0;
      fma_c   = '0;
      push    = 1'b0;
      push_id = T_RE1;
      case (state)
         S_P1_RE: begin
            fma_a   = ar;
            fma_b   = br;
            push    = 1'b1;
            push_id = T_RE1;
         end
         S_P1_IM: begin
            fma_a   = ar;
            fma_b   = bi;
            push    = 1'b1;
            push_id = T_IM1;
         end
         S_P2_RE: begin
            fma_a   = {~ai[DW-1], ai[DW-2:0]};
            fma_b   = bi;
            fma_c   = re_p;
            push    = 1'b1;
            push_id = T_RE2;
         end
         S_P2_IM: begin
            fma_a   = ai;
            fma_b   = br;
            fma_c   = im_p;
            push    = 1'b1;
            push_id = T_IM2;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = S_P1_RE;
         S_P1_RE: state_nx = S_P1_IM;
         S_P1_IM: state_nx = S_W1;
         S_W1:    if (cap_re1 | have_re) state_nx = S_P2_RE;
         S_P2_RE: if (cap_im1 | have_im) state_nx = S_P2_IM;
         S_P2_IM: state_nx = S_W2;
         S_W2:    if (cap_im2) state_nx = S_DONE;
         S_DONE:  if (out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         en_q    <= 1'b0;
         err_q   <= 1'b0;
         have_re <= 1'b0;
         have_im <= 1'b0;
         ar      <= '0;
         ai      <= '0;
         br      <= '0;
         bi      <= '0;
         re_p    <= '0;
         im_p    <= '0;
         out_re  <= '0;
         out_im  <= '0;
      end else begin
         state <= state_nx;
         en_q  <= 1'b1;
         err_q <= seq_err;
         if (accept) begin
            ar      <= in_a_re;
            ai      <= in_a_im;
            br      <= in_b_re;
            bi      <= in_b_im;
            have_re <= 1'b0;
            have_im <= 1'b0;
         end
         if (cap_re1) have_re <= 1'b1;
         if (cap_im1) have_im <= 1'b1;
         if (exit_v) begin
            case (exit_id)
               T_RE1:   re_p   <= fma_result;
               T_IM1:   im_p   <= fma_result;
               T_RE2:   out_re <= fma_result;
               default: out_im <= fma_result;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fp_cmul_seq.sv
// Directed bench for fp_cmul_seq with a behavioural fixed-latency FMA.
// Two builds are exercised: FMA_LAT=3 and FMA_LAT=5.
module tb_fp_cmul_seq;

   localparam int L3 = 3;
   localparam int L5 = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] a_re, a_im, b_re, b_im;

   logic        iv3, ir3, en3, fv3, ov3, or3, err3;
   logic [31:0] fa3, fb3, fc3, fr3, ore3, oim3;
   logic        iv5, ir5, en5, fv5, ov5, or5, err5;
   logic [31:0] fa5, fb5, fc5, fr5, ore5, oim5;

   logic        kill = 1'b0;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          issues = 0;
   int          acc_n = 0;
   int          hs_n = 0;
   int          acc_c [4];
   int          hs_c [4];
   logic [31:0] hs_re [4];
   logic [31:0] hs_im [4];

   always #5 clk = ~clk;

   fp_cmul_seq #(.FMA_LAT(L3)) dut3 (
      .clk(clk), .reset(reset),
      .in_valid(iv3), .in_ready(ir3),
      .in_a_re(a_re), .in_a_im(a_im),
      .in_b_re(b_re), .in_b_im(b_im),
      .fma_enable(en3), .fma_a(fa3), .fma_b(fb3), .fma_c(fc3),
      .fma_result(fr3), .fma_valid(fv3),
      .out_valid(ov3), .out_ready(or3),
      .out_re(ore3), .out_im(oim3), .seq_err(err3)
   );

   fp_cmul_seq #(.FMA_LAT(L5)) dut5 (
      .clk(clk), .reset(reset),
      .in_valid(iv5), .in_ready(ir5),
      .in_a_re(a_re), .in_a_im(a_im),
      .in_b_re(b_re), .in_b_im(b_im),
      .fma_enable(en5), .fma_a(fa5), .fma_b(fb5), .fma_c(fc5),
      .fma_result(fr5), .fma_valid(fv5),
      .out_valid(ov5), .out_ready(or5),
      .out_re(ore5), .out_im(oim5), .seq_err(err5)
   );

   function automatic real sp2r(input logic [31:0] x);
      real r;
      int  e;
      if (x[30:0] == 31'd0) return 0.0;
      e = int'(x[30:23]) - 127;
      r = 1.0 + real'(x[22:0]) / 8388608.0;
      if (e > 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else for (int i = 0; i < -e; i++) r = r / 2.0;
      return x[31] ? -r : r;
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      int          e;
      logic [7:0]  e8;
      if (r == 0.0) return 32'h0;
      d  = $realtobits(r);
      e  = int'(d[62:52]) - 1023 + 127;
      e8 = e[7:0];
      return {d[63], e8, d[51:29]};
   endfunction

   logic [31:0] mr3 [L3];
   logic        mv3 [L3];
   logic [31:0] mr5 [L5];
   logic        mv5 [L5];

   initial begin
      for (int i = 0; i < L3; i++) begin mr3[i] = 0; mv3[i] = 0; end
      for (int i = 0; i < L5; i++) begin mr5[i] = 0; mv5[i] = 0; end
   end

   always @(posedge clk) begin
      mr3[0] <= r2sp(sp2r(fa3) * sp2r(fb3) + sp2r(fc3));
      mv3[0] <= en3;
      for (int i = 1; i < L3; i++) begin
         mr3[i] <= mr3[i-1];
         mv3[i] <= mv3[i-1];
      end
      mr5[0] <= r2sp(sp2r(fa5) * sp2r(fb5) + sp2r(fc5));
      mv5[0] <= en5;
      for (int i = 1; i < L5; i++) begin
         mr5[i] <= mr5[i-1];
         mv5[i] <= mv5[i-1];
      end
   end

   assign fr3 = mr3[L3-1];
   assign fv3 = mv3[L3-1] & ~kill;
   assign fr5 = mr5[L5-1];
   assign fv5 = mv5[L5-1];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fa3 != 0 || fb3 != 0) issues <= issues + 1;
      if (iv3 && ir3 && acc_n < 4) begin
         acc_c[acc_n] <= cyc;
         acc_n <= acc_n + 1;
      end
      if (ov3 && or3 && hs_n < 4) begin
         hs_c[hs_n]  <= cyc;
         hs_re[hs_n] <= ore3;
         hs_im[hs_n] <= oim3;
         hs_n <= hs_n + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int sel, input logic [31:0] ar,
                        input logic [31:0] ai, input logic [31:0] br,
                        input logic [31:0] bi);
      int n;
      a_re = ar; a_im = ai; b_re = br; b_im = bi;
      n = 0;
      while (!((sel == 3) ? ir3 : ir5) && n < 30) begin
         tick();
         n++;
      end
      chk("in_ready_timeout", 32'(n < 30), 32'd1);
      if (sel == 3) iv3 = 1'b1; else iv5 = 1'b1;
      tick();
      iv3 = 1'b0;
      iv5 = 1'b0;
   endtask

   task automatic wait_out3();
      int n;
      n = 0;
      while (!ov3 && n < 40) begin
         tick();
         n++;
      end
      chk("out_valid_timeout", 32'(n < 40), 32'd1);
   endtask

   initial begin
      reset = 1'b0;
      iv3 = 0; or3 = 0; iv5 = 0; or5 = 0;
      a_re = 0; a_im = 0; b_re = 0; b_im = 0;
      tick();
      tick();
      chk("rst_in_ready", 32'(ir3), 32'd0);
      chk("rst_out_valid", 32'(ov3), 32'd0);
      chk("rst_fma_enable", 32'(en3), 32'd0);
      chk("rst_out_re", ore3, 32'h0);
      chk("rst_seq_err", 32'(err3), 32'd0);
      reset = 1'b1;
      tick();
      tick();
      chk("fma_enable_on", 32'(en3), 32'd1);

      // test 1: (1+2i)*(3+4i) = -5+10i
      start(3, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
      chk("t1_p1re_a", fa3, 32'h3F800000);
      chk("t1_p1re_b", fb3, 32'h40400000);
      chk("t1_p1re_c", fc3, 32'h0);
      tick();
      chk("t1_p1im_b", fb3, 32'h40800000);
      chk("t1_p1im_c", fc3, 32'h0);
      tick();
      chk("t1_w1_idle_a", fa3, 32'h0);
      tick();
      tick();
      chk("t1_p2re_a", fa3, 32'hC0000000);
      chk("t1_p2re_b", fb3, 32'h40800000);
      chk("t1_p2re_c", fc3, 32'h40400000);
      tick();
      chk("t1_p2im_a", fa3, 32'h40000000);
      chk("t1_p2im_b", fb3, 32'h40400000);
      chk("t1_p2im_c", fc3, 32'h40800000);
      tick(); tick(); tick();
      chk("t1_ov_t9", 32'(ov3), 32'd0);
      tick();
      chk("t1_ov_t10", 32'(ov3), 32'd1);
      chk("t1_out_re", ore3, 32'hC0A00000);
      chk("t1_out_im", oim3, 32'h41200000);
      chk("t1_seq_err", 32'(err3), 32'd0);

      // test 2: output stall
      issues = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_ov_hold", 32'(ov3), 32'd1);
         chk("t2_re_hold", ore3, 32'hC0A00000);
         chk("t2_im_hold", oim3, 32'h41200000);
         chk("t2_in_ready", 32'(ir3), 32'd0);
      end
      chk("t2_no_issue", 32'(issues), 32'd0);
      or3 = 1'b1;
      tick();
      or3 = 1'b0;
      chk("t2_ov_drop", 32'(ov3), 32'd0);

      // test 3: back-to-back, (2+i)*(1-i) = 3-i
      tick();
      issues = 0; acc_n = 0; hs_n = 0;
      a_re = 32'h40000000; a_im = 32'h3F800000;
      b_re = 32'h3F800000; b_im = 32'hBF800000;
      iv3 = 1'b1; or3 = 1'b1;
      for (int i = 0; i < 60 && hs_n < 2; i++) tick();
      iv3 = 1'b0;
      chk("t3_two_outputs", 32'(hs_n), 32'd2);
      chk("t3_accepts", 32'(acc_n), 32'd2);
      chk("t3_b2b_accept", 32'(acc_c[1]), 32'(hs_c[0] + 1));
      chk("t3_re0", hs_re[0], 32'h40400000);
      chk("t3_im0", hs_im[0], 32'hBF800000);
      chk("t3_re1", hs_re[1], 32'h40400000);
      chk("t3_im1", hs_im[1], 32'hBF800000);
      tick();
      chk("t3_issue_count", 32'(issues), 32'd8);
      or3 = 1'b0;

      // test 4: reset mid-transaction at T+6
      start(3, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b0;
      #1;
      chk("t4_rst_ov", 32'(ov3), 32'd0);
      chk("t4_rst_fma_a", fa3, 32'h0);
      chk("t4_rst_fma_c", fc3, 32'h0);
      chk("t4_rst_enable", 32'(en3), 32'd0);
      chk("t4_rst_out_re", ore3, 32'h0);
      tick();
      reset = 1'b1;
      start(3, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'hBF800000);
      wait_out3();
      chk("t4_out_re", ore3, 32'h40400000);
      chk("t4_out_im", oim3, 32'hBF800000);
      chk("t4_seq_err", 32'(err3), 32'd0);
      or3 = 1'b1;
      tick();
      or3 = 1'b0;

      // test 5: fma_valid dropped while re1 tag exits at T+4
      start(3, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
      tick(); tick();
      chk("t5_err_before", 32'(err3), 32'd0);
      tick();
      kill = 1'b1;
      #1;
      chk("t5_err_t4", 32'(err3), 32'd1);
      tick();
      kill = 1'b0;
      #1;
      chk("t5_err_sticky", 32'(err3), 32'd1);
      wait_out3();
      chk("t5_out_re", ore3, 32'hC0A00000);
      chk("t5_out_im", oim3, 32'h41200000);
      or3 = 1'b1;
      tick();
      or3 = 1'b0;
      start(3, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'hBF800000);
      wait_out3();
      chk("t5_out_re2", ore3, 32'h40400000);
      chk("t5_err_later", 32'(err3), 32'd1);
      or3 = 1'b1;
      tick();
      or3 = 1'b0;
      reset = 1'b0;
      #1;
      chk("t5_err_reset", 32'(err3), 32'd0);
      tick();
      reset = 1'b1;
      tick();

      // test 6: FMA_LAT=5 build
      start(5, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
      chk("t6_p1re_a", fa5, 32'h3F800000);
      for (int i = 0; i < 12; i++) tick();
      chk("t6_ov_t13", 32'(ov5), 32'd0);
      tick();
      chk("t6_ov_t14", 32'(ov5), 32'd1);
      chk("t6_out_re", ore5, 32'hC0A00000);
      chk("t6_out_im", oim5, 32'h41200000);
      chk("t6_seq_err", 32'(err5), 32'd0);
      or5 = 1'b1;
      tick();
      or5 = 1'b0;
      chk("t6_ov_drop", 32'(ov5), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
